inv_factorial_seq: RTL and testbench
====================================

// Module: inv_factorial_seq
//
// PURPOSE
//  Inverse of the factorial datapath. Given a 32-bit value, it finds the largest n
//  such that n! <= value and flags whether value == n! exactly.
//  Uses the factorial convention 0! := 0, 1! := 1, k! = k*(k-1)! for k >= 2.
//  Iterative multiply-and-compare engine, one step per clock, with a start/busy/done handshake.
//  Consumers: test/readback logic that must recover n from a registered factorial result.
//
// PARAMETERS
//  WIDTH  32  bit width of the value operand
//  NW     4   bit width of the n result
//  NMAX   12  largest n with n! < 2**WIDTH; iteration stops at k == NMAX
//
// PORTS
//  clk     in   1      single clock; all state updates on the posedge
//  reset   in   1      synchronous, active-high; sampled on the clk posedge
//  start   in   1      request; accepted only when busy==0
//  value   in   WIDTH  operand; sampled on the accepting edge only
//  busy    out  1      1 from the accepting edge until done is raised
//  done    out  1      single-cycle pulse when n/exact become valid
//  n       out  NW     largest n with n! <= value; held until the next done
//  exact   out  1      1 iff value == n!; held with n
//
// BEHAVIOUR
//  - Reset: state=IDLE; busy=0, done=0, n=0, exact=0; internal prod/k/val cleared.
//    This applies in any state, including mid-CALC. The op in flight is abandoned and no done is produced.
//  - States: IDLE, CALC.
//  - IDLE & start: val<=value, prod<=1, k<=1, busy<=1 -> CALC. Start while busy is ignored (not queued).
//  - CALC, each cycle:
//    - If val==0: finish with n=0, exact=1.
//    - Else compute nxt = prod*(k+1) at full width (WIDTH+NW bits, no truncation).
//    - If k==NMAX or nxt > val: finish with n=k, exact=(prod==val).
//    - Else prod<=nxt[WIDTH-1:0], k<=k+1.
//  - Finish (same edge): n/exact registered, done<=1 for exactly one cycle, busy<=0 -> IDLE.
//  - Latency: done is high max(n,1) cycles after the accepting edge.
//    Examples: value 0/1 -> 1 cycle; 120 -> 5 cycles; >= 12! -> 12 cycles.
//  - A start in the done cycle is accepted; this is the back-to-back rule, throughput 1 op per N+1 cycles max.
//  - value changes while busy have no effect.
//  - The compare must not overflow: at k==NMAX the product is never written back.
//
// STRUCTURE
//  - Shared package invfact_pkg:
//    - NMAX/WIDTH/NW constants.
//    - State enum {IDLE, CALC}.
//    - Function fact_ref(n) giving the golden factorial with the 0!:=0 convention, for bench reuse.
//  - One combinational sub-module, fact_step. It takes prod, k and val, and returns nxt and stop.
//    It isolates the widened multiplier/comparator from the FSM.
//  - Top: FSM plus registers only.
//
// TESTING
//  1. value=120, start 1 cycle -> done after 5 cycles; n=5, exact=1; busy high 5 cycles.
//  2. value=119 -> done after 4 cycles; n=4, exact=0. value=121 -> n=5, exact=0.
//  3. value=0 -> n=0, exact=1 after 1 cycle. value=1 -> n=1, exact=1 after 1 cycle.
//     value=2 -> n=2, exact=1 after 2 cycles.
//  4. value=479001600 -> n=12, exact=1. value=32'hFFFF_FFFF -> n=12, exact=0. Both take 12 cycles, no wrap.
//  5. value=720 is started. Pulse start with value=6 at cycle 2 -> ignored; result n=6, exact=1.
//     Then start with value=6 in the done cycle -> accepted; n=3, exact=1 after 3 more cycles.
//  6. reset high for 1 cycle during CALC (value=5040, cycle 3) -> next cycle busy=0, done=0, n=0, exact=0.
//     No done is produced for that op. A fresh start with value=24 -> n=4, exact=1.
//  Sweep all n in 0..12 at n!, n!-1 and n!+1 against fact_ref.

Source files
------------

// File: rtl/invfact_pkg.sv
// invfact_pkg: shared constants, FSM state type and golden factorial for the inverse-factorial engine.
package invfact_pkg;
    localparam int WIDTH = 32;
    localparam int NW = 4;
    localparam int NMAX = 12;
    typedef enum logic {IDLE, CALC} state_t;
    // 0! is defined as 0 here so that value 0 maps to n=0 exactly.
    function automatic logic [63:0] fact_ref(input int unsigned k);
        logic [63:0] f;
        if (k == 0) return 64'd0;
        f = 64'd1;
        for (int unsigned i = 2; i <= k; i++) f = f * 64'(i);
        return f;
    endfunction
endpackage

// File: rtl/fact_step.sv
// fact_step: widened next-factorial multiply and stop compare for one iteration.
module fact_step #(
    parameter int WIDTH = invfact_pkg::WIDTH,
    parameter int NW = invfact_pkg::NW,
    parameter int NMAX = invfact_pkg::NMAX
) (
    input  logic [WIDTH-1:0]    prod,
    input  logic [NW-1:0]       k,
    input  logic [WIDTH-1:0]    val,
    output logic [WIDTH+NW-1:0] nxt,
    output logic                stop
);
    // k+1 never exceeds NMAX+1, so WIDTH+NW bits hold the product without wrap.
    assign nxt = {{NW{1'b0}}, prod} * ((WIDTH+NW)'(k) + (WIDTH+NW)'(1));
    assign stop = (k == NW'(NMAX)) || (nxt > {{NW{1'b0}}, val});
endmodule

// File: rtl/inv_factorial_seq.sv
// inv_factorial_seq: finds largest n with n! <= value, one multiply-compare step per clock.
module inv_factorial_seq #(
    parameter int WIDTH = invfact_pkg::WIDTH,
    parameter int NW = invfact_pkg::NW,
    parameter int NMAX = invfact_pkg::NMAX
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic [NW-1:0]    n,
    output logic             exact
);
    import invfact_pkg::*;

    state_t state, state_nxt;
    logic [WIDTH-1:0] prod, val;
    logic [NW-1:0] k;
    logic [WIDTH+NW-1:0] nxt;
    logic stop, accept, fin, adv;

    fact_step #(.WIDTH(WIDTH), .NW(NW), .NMAX(NMAX)) u_step (
        .prod(prod),
        .k(k),
        .val(val),
        .nxt(nxt),
        .stop(stop)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (accept) state_nxt = CALC;
        else if (fin) state_nxt = IDLE;
    end

    always_comb begin
        busy = (state == CALC);
        accept = (state == IDLE) && start;
        fin = busy && ((val == '0) || stop);
        adv = busy && !fin;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod <= '0;
            val <= '0;
            k <= '0;
            done <= 1'b0;
            n <= '0;
            exact <= 1'b0;
        end else begin
            done <= fin;
            if (accept) begin
                val <= value;
                prod <= WIDTH'(1);
                k <= NW'(1);
            end else if (adv) begin
                prod <= nxt[WIDTH-1:0];
                k <= k + NW'(1);
            end
            if (fin) begin
                n <= (val == '0) ? '0 : k;
                exact <= (val == '0) ? 1'b1 : (prod == val);
            end
        end
    end
endmodule

// File: tb/tb_inv_factorial_seq.sv
// tb_inv_factorial_seq: directed and randomized checks against a factorial-table reference model.
module tb_inv_factorial_seq;
    import invfact_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [31:0] value = '0;
    logic busy, done, exact;
    logic [3:0] n;
    int checks = 0;
    int errors = 0;

    inv_factorial_seq dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .value(value),
        .busy(busy),
        .done(done),
        .n(n),
        .exact(exact)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Largest n in 0..12 whose factorial fits under v, by table lookup.
    task automatic ref_model(input logic [31:0] v, output int en, output logic ee);
        en = 0;
        for (int i = 0; i <= 12; i++) if (fact_ref(i) <= 64'(v)) en = i;
        ee = (fact_ref(en) == 64'(v));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [31:0] v);
        start = 1'b1;
        value = v;
        step();
        start = 1'b0;
        value = $urandom;
    endtask

    task automatic wait_done(output int cyc);
        logic got;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            check("busy_during", 64'(busy), 64'(1));
            step();
            cyc++;
            got = done;
        end
        if (!got) check("timeout", 64'(0), 64'(1));
        check("busy_after", 64'(busy), 64'(0));
    endtask

    task automatic expect_result(input logic [31:0] v, input int cyc);
        int en;
        logic ee;
        ref_model(v, en, ee);
        check("n", 64'(n), 64'(en));
        check("exact", 64'(exact), 64'(ee));
        check("latency", 64'(cyc), 64'((en == 0) ? 1 : en));
    endtask

    task automatic run_op(input logic [31:0] v);
        int cyc;
        launch(v);
        wait_done(cyc);
        expect_result(v, cyc);
        step();
        check("done_pulse", 64'(done), 64'(0));
    endtask

    initial begin
        int cyc;
        logic [31:0] v;
        step();
        step();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_n", 64'(n), 64'(0));
        check("rst_exact", 64'(exact), 64'(0));
        reset = 1'b0;
        step();

        foreach (v_dir[i]) run_op(v_dir[i]);

        // A start while busy is dropped; a start in the done cycle is taken.
        launch(32'd720);
        step();
        start = 1'b1;
        value = 32'd6;
        step();
        start = 1'b0;
        value = 32'd0;
        wait_done(cyc);
        expect_result(32'd720, cyc + 2);
        launch(32'd6);
        wait_done(cyc);
        expect_result(32'd6, cyc);
        step();

        // Reset mid-calculation abandons the op without a done.
        launch(32'd5040);
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_n", 64'(n), 64'(0));
        check("mid_rst_exact", 64'(exact), 64'(0));
        for (int i = 0; i < 12; i++) begin
            step();
            check("no_done_after_rst", 64'(done), 64'(0));
        end
        run_op(32'd24);

        for (int i = 0; i <= 12; i++) begin
            v = 32'(fact_ref(i));
            run_op(v);
            run_op(v - 32'd1);
            run_op(v + 32'd1);
        end

        for (int i = 0; i < 40; i++) begin
            v = 32'(fact_ref($urandom_range(12, 0)));
            case ($urandom_range(3, 0))
                0: v = $urandom;
                1: v = v + 32'($urandom_range(3, 0));
                2: v = v - 32'($urandom_range(3, 0));
                default: v = v >> $urandom_range(3, 0);
            endcase
            run_op(v);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    logic [31:0] v_dir [10] = '{32'd120, 32'd119, 32'd121, 32'd0, 32'd1, 32'd2,
                                32'd479001600, 32'hFFFF_FFFF, 32'd3628800, 32'd6227020};
endmodule
